controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 char_valid  input  1  one-cycle strobe: new guessed letter present at datapath input.
REQ-005 input_char_eq_word  input  5  per-position match of latched letter vs 5-letter word; bit i = position i.
REQ-006 guessed_letters_is_done  input  1  datapath flag: all word positions guessed.
REQ-007 tries_is_zero  input  1  datapath flag: remaining-tries counter equals 0.
REQ-008 new_game  input  1  one-cycle strobe: start next game.
REQ-009 en_input_char  output  1  load input-letter register.
REQ-010 en_word_index  output  1  advance word-select index.
REQ-011 s_tries / en_tries  output  1/1  tries register: en=1 with s=1 loads max, s=0 decrements.
REQ-012 s_guessed_letters  output  3  binary position index 0..4 to mark guessed.
REQ-013 en_guessed_letters  output  3  bit0 set position s_guessed_letters; bit1 clear all; bit2 always 0.
REQ-014 s_win / en_win, s_lose / en_lose  output  1 each  win/lose flag registers load s_* when en_*=1.

Function
REQ-015 Outputs SHALL be combinational Moore decode of state register and internal 5-bit match mask; any output not listed for a state is 0.
REQ-016 States: RST, INIT, WAIT, LOAD, CHECK, MARK, MISS, EVAL, WIN, LOSE, DONE.
REQ-017 RST: all outputs 0; unconditionally -> INIT next cycle.
REQ-018 INIT: en_tries=1, s_tries=1, en_guessed_letters=3'b010, en_win=1, s_win=0, en_lose=1, s_lose=0, en_word_index=1; -> WAIT.
REQ-019 WAIT: char_valid=1 -> LOAD, else stay.
REQ-020 LOAD: en_input_char=1; -> CHECK.
REQ-021 CHECK: mask captures input_char_eq_word; nonzero -> MARK, zero -> MISS.
REQ-022 MARK: s_guessed_letters = index of lowest set mask bit, en_guessed_letters=3'b001; that bit cleared; one position per cycle; mask zero after clear -> EVAL, else stay.
REQ-023 MISS: en_tries=1, s_tries=0; -> EVAL.
REQ-024 EVAL: guessed_letters_is_done -> WIN; else tries_is_zero -> LOSE; else -> WAIT; simultaneous done and zero SHALL give WIN.
REQ-025 WIN: en_win=1, s_win=1; -> DONE. LOSE: en_lose=1, s_lose=1; -> DONE.
REQ-026 DONE: new_game=1 -> INIT; char_valid ignored.
REQ-027 char_valid in any state other than WAIT (or DONE per REQ-031) SHALL be ignored, not queued.
REQ-028 Mask SHALL only change in CHECK and MARK.

Reset
REQ-029 rst_n low SHALL asynchronously force state=RST and mask=0, giving all-zero outputs, including mid-game.
REQ-030 After rst_n rises: one RST cycle, one INIT cycle, then WAIT.

Configuration
REQ-031 CONTROLLER_AUTO_RESTART_EN defined: DONE also -> INIT on char_valid (letter discarded); undefined: DONE leaves only on new_game.

Verification
REQ-032 Reset release -> RST 1 cycle all zero; INIT cycle en_tries=1, s_tries=1, en_guessed_letters=010, en_word_index=1, en_win=1, en_lose=1; then idle.
REQ-033 char_valid in WAIT, match=5'b10010 -> LOAD en_input_char=1; MARK cycles s_guessed_letters=1 then 4 with en_guessed_letters=001; EVAL; WAIT.
REQ-034 char_valid, match=0, tries_is_zero=1 in EVAL -> MISS en_tries=1, s_tries=0; LOSE en_lose=1, s_lose=1; DONE.
REQ-035 match=5'b00001, guessed_letters_is_done=1 and tries_is_zero=1 in EVAL -> WIN en_win=1, s_win=1.
REQ-036 In DONE: char_valid -> stays DONE (macro off) or -> INIT (macro on); new_game -> INIT either way.
REQ-037 rst_n low mid-MARK -> outputs 0 immediately; restart via RST then INIT.

Source files
------------

// File: rtl/controller.sv
// Game controller FSM: sequences letter load, match marking, miss accounting and win/lose flags.
// Optional CONTROLLER_AUTO_RESTART_EN: a letter strobe in DONE also restarts the game (letter discarded).
module controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       char_valid,
    input  logic [4:0] input_char_eq_word,
    input  logic       guessed_letters_is_done,
    input  logic       tries_is_zero,
    input  logic       new_game,
    output logic       en_input_char,
    output logic       en_word_index,
    output logic       s_tries,
    output logic       en_tries,
    output logic [2:0] s_guessed_letters,
    output logic [2:0] en_guessed_letters,
    output logic       s_win,
    output logic       en_win,
    output logic       s_lose,
    output logic       en_lose
);

    typedef enum logic [3:0] {
        ST_RST, ST_INIT, ST_WAIT, ST_LOAD, ST_CHECK, ST_MARK,
        ST_MISS, ST_EVAL, ST_WIN, ST_LOSE, ST_DONE
    } state_t;

    state_t     state_q;
    logic [4:0] mask_q;
    logic [4:0] mask_clr_d;
    logic [2:0] low_idx;
    logic       restart_on_char;

`ifdef CONTROLLER_AUTO_RESTART_EN
    assign restart_on_char = char_valid;
`else
    assign restart_on_char = 1'b0;
`endif

    // Drop the lowest set bit: one word position is marked per MARK cycle.
    assign mask_clr_d = mask_q & (mask_q - 5'd1);

    always_comb begin
        low_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (mask_q[i]) low_idx = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
            mask_q  <= 5'd0;
        end else begin
            case (state_q)
                ST_RST:   state_q <= ST_INIT;
                ST_INIT:  state_q <= ST_WAIT;
                ST_WAIT:  if (char_valid) state_q <= ST_LOAD;
                ST_LOAD:  state_q <= ST_CHECK;
                ST_CHECK: begin
                    mask_q  <= input_char_eq_word;
                    state_q <= (input_char_eq_word != 5'd0) ? ST_MARK : ST_MISS;
                end
                ST_MARK: begin
                    mask_q <= mask_clr_d;
                    if (mask_clr_d == 5'd0) state_q <= ST_EVAL;
                end
                ST_MISS:  state_q <= ST_EVAL;
                ST_EVAL: begin
                    if (guessed_letters_is_done) state_q <= ST_WIN;
                    else if (tries_is_zero)      state_q <= ST_LOSE;
                    else                         state_q <= ST_WAIT;
                end
                ST_WIN:   state_q <= ST_DONE;
                ST_LOSE:  state_q <= ST_DONE;
                ST_DONE:  if (new_game || restart_on_char) state_q <= ST_INIT;
                default:  state_q <= ST_RST;
            endcase
        end
    end

    always_comb begin
        en_input_char      = 1'b0;
        en_word_index      = 1'b0;
        s_tries            = 1'b0;
        en_tries           = 1'b0;
        s_guessed_letters  = 3'd0;
        en_guessed_letters = 3'd0;
        s_win              = 1'b0;
        en_win             = 1'b0;
        s_lose             = 1'b0;
        en_lose            = 1'b0;
        case (state_q)
            ST_INIT: begin
                en_tries           = 1'b1;
                s_tries            = 1'b1;
                en_guessed_letters = 3'b010;
                en_win             = 1'b1;
                en_lose            = 1'b1;
                en_word_index      = 1'b1;
            end
            ST_LOAD: en_input_char = 1'b1;
            ST_MARK: begin
                s_guessed_letters  = low_idx;
                en_guessed_letters = 3'b001;
            end
            ST_MISS: en_tries = 1'b1;
            ST_WIN: begin
                en_win = 1'b1;
                s_win  = 1'b1;
            end
            ST_LOSE: begin
                en_lose = 1'b1;
                s_lose  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: directed guess table, reset corner cases, randomized games.
module tb_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       char_valid;
    logic [4:0] input_char_eq_word;
    logic       guessed_letters_is_done;
    logic       tries_is_zero;
    logic       new_game;
    logic       en_input_char, en_word_index, s_tries, en_tries;
    logic [2:0] s_guessed_letters, en_guessed_letters;
    logic       s_win, en_win, s_lose, en_lose;

    always #5 clk = ~clk;

    controller dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .char_valid              (char_valid),
        .input_char_eq_word      (input_char_eq_word),
        .guessed_letters_is_done (guessed_letters_is_done),
        .tries_is_zero           (tries_is_zero),
        .new_game                (new_game),
        .en_input_char           (en_input_char),
        .en_word_index           (en_word_index),
        .s_tries                 (s_tries),
        .en_tries                (en_tries),
        .s_guessed_letters       (s_guessed_letters),
        .en_guessed_letters      (en_guessed_letters),
        .s_win                   (s_win),
        .en_win                  (en_win),
        .s_lose                  (s_lose),
        .en_lose                 (en_lose)
    );

    // {en_input_char, en_word_index, s_tries, en_tries, s_gl[2:0], en_gl[2:0], s_win, en_win, s_lose, en_lose}
    logic [13:0] dut_o;
    assign dut_o = {en_input_char, en_word_index, s_tries, en_tries, s_guessed_letters,
                    en_guessed_letters, s_win, en_win, s_lose, en_lose};

    localparam logic [13:0] V_IDLE = 14'b0_0_0_0_000_000_0_0_0_0;
    localparam logic [13:0] V_INIT = 14'b0_1_1_1_000_010_0_1_0_1;
    localparam logic [13:0] V_LOAD = 14'b1_0_0_0_000_000_0_0_0_0;
    localparam logic [13:0] V_MISS = 14'b0_0_0_1_000_000_0_0_0_0;
    localparam logic [13:0] V_WIN  = 14'b0_0_0_0_000_000_1_1_0_0;
    localparam logic [13:0] V_LOSE = 14'b0_0_0_0_000_000_0_0_1_1;

    localparam int END_CONT = 0;
    localparam int END_WIN  = 1;
    localparam int END_LOSE = 2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0] match;
        logic       done;
        logic       zero;
        int         exp_end;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [13:0] v_mark(input int pos);
        logic [13:0] v;
        v = V_IDLE;
        v[9:7] = 3'(pos);
        v[6:4] = 3'b001;
        return v;
    endfunction

    // Outcome rule of the evaluation step: completion beats exhausted tries.
    function automatic int ref_outcome(input logic done, input logic zero);
        if (done) return END_WIN;
        if (zero) return END_LOSE;
        return END_CONT;
    endfunction

    task automatic compare(input logic [13:0] exp, input string name);
        n_checks++;
        if (dut_o !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs=%b expected=%b at %0t", name, dut_o, exp, $time);
        end
    endtask

    // Inputs set by the caller are sampled at the posedge closing this cycle.
    task automatic expect_cycle(input logic [13:0] exp, input string name);
        @(negedge clk);
        compare(exp, name);
        @(posedge clk);
        #1;
    endtask

    task automatic noise(input bit on);
        char_valid = on ? 1'($urandom_range(0, 1)) : 1'b0;
        new_game   = on ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    // Starts in WAIT; ends in WAIT (continue) or DONE (win/lose).
    task automatic do_guess(input logic [4:0] match, input logic done, input logic zero,
                            input int exp_end, input bit noisy, input string name);
        char_valid = 1'b1;
        new_game = 1'b0;
        input_char_eq_word = match;
        guessed_letters_is_done = done;
        tries_is_zero = zero;
        expect_cycle(V_IDLE, {name, "/wait"});
        noise(noisy);
        expect_cycle(V_LOAD, {name, "/load"});
        noise(noisy);
        expect_cycle(V_IDLE, {name, "/check"});
        if (noisy) input_char_eq_word = 5'($urandom);
        if (match == 5'd0) begin
            noise(noisy);
            expect_cycle(V_MISS, {name, "/miss"});
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (match[i]) begin
                    noise(noisy);
                    expect_cycle(v_mark(i), {name, "/mark"});
                end
            end
        end
        noise(noisy);
        expect_cycle(V_IDLE, {name, "/eval"});
        if (exp_end == END_WIN) begin
            noise(noisy);
            expect_cycle(V_WIN, {name, "/win"});
        end else if (exp_end == END_LOSE) begin
            noise(noisy);
            expect_cycle(V_LOSE, {name, "/lose"});
        end
        char_valid = 1'b0;
        new_game = 1'b0;
    endtask

    // Starts in DONE; ends in WAIT after the INIT cycle.
    task automatic finish_game(input bit use_char);
        if (use_char) begin
            char_valid = 1'b1;
            expect_cycle(V_IDLE, "done/char");
            char_valid = 1'b0;
`ifdef CONTROLLER_AUTO_RESTART_EN
            expect_cycle(V_INIT, "done/auto_init");
`else
            expect_cycle(V_IDLE, "done/char_ignored");
            new_game = 1'b1;
            expect_cycle(V_IDLE, "done/new_game");
            new_game = 1'b0;
            expect_cycle(V_INIT, "done/init");
`endif
        end else begin
            new_game = 1'b1;
            expect_cycle(V_IDLE, "done/new_game");
            new_game = 1'b0;
            expect_cycle(V_INIT, "done/init");
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        expect_cycle(V_IDLE, "rst_cycle");
        expect_cycle(V_INIT, "init_cycle");
    endtask

    initial begin
        rst_n = 1'b1;
        char_valid = 1'b0;
        input_char_eq_word = 5'd0;
        guessed_letters_is_done = 1'b0;
        tries_is_zero = 1'b0;
        new_game = 1'b0;

        vecs.push_back('{5'b10010, 1'b0, 1'b0, END_CONT, "two_marks"});
        vecs.push_back('{5'b00000, 1'b0, 1'b1, END_LOSE, "miss_lose"});
        vecs.push_back('{5'b00001, 1'b1, 1'b1, END_WIN,  "done_and_zero"});
        vecs.push_back('{5'b00000, 1'b0, 1'b0, END_CONT, "miss_cont"});
        vecs.push_back('{5'b11111, 1'b1, 1'b0, END_WIN,  "all_marks_win"});
        vecs.push_back('{5'b10000, 1'b0, 1'b1, END_LOSE, "mark_then_lose"});
        vecs.push_back('{5'b00000, 1'b1, 1'b1, END_WIN,  "miss_done_zero"});
        vecs.push_back('{5'b01100, 1'b0, 1'b0, END_CONT, "mid_marks"});

        #2 rst_n = 1'b0;
        #1 compare(V_IDLE, "reset_state");
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        expect_cycle(V_IDLE, "wait_idle");

        foreach (vecs[i]) begin
            do_guess(vecs[i].match, vecs[i].done, vecs[i].zero, vecs[i].exp_end, 1'b0, vecs[i].name);
            if (vecs[i].exp_end != END_CONT) finish_game(i[0]);
        end

        // Asynchronous reset in the middle of a multi-position mark.
        char_valid = 1'b1;
        input_char_eq_word = 5'b11111;
        guessed_letters_is_done = 1'b0;
        tries_is_zero = 1'b0;
        expect_cycle(V_IDLE, "rstmid/wait");
        char_valid = 1'b0;
        expect_cycle(V_LOAD, "rstmid/load");
        expect_cycle(V_IDLE, "rstmid/check");
        expect_cycle(v_mark(0), "rstmid/mark0");
        compare(v_mark(1), "rstmid/mark1");
        rst_n = 1'b0;
        #1 compare(V_IDLE, "rstmid/async_zero");
        @(posedge clk);
        #1;
        compare(V_IDLE, "rstmid/held");
        release_reset();

        // Randomized games against the outcome rule.
        for (int g = 0; g < 30; g++) begin
            int outcome;
            outcome = END_CONT;
            for (int k = 0; k < 6 && outcome == END_CONT; k++) begin
                logic [4:0] m;
                logic d, z;
                int idle;
                idle = $urandom_range(0, 2);
                for (int c = 0; c < idle; c++) begin
                    char_valid = 1'b0;
                    new_game = 1'($urandom_range(0, 1));
                    expect_cycle(V_IDLE, "rand/wait_idle");
                end
                m = 5'($urandom);
                d = ($urandom_range(0, 3) == 0);
                z = ($urandom_range(0, 3) == 0);
                outcome = ref_outcome(d, z);
                do_guess(m, d, z, outcome, 1'b1, "rand");
            end
            if (outcome == END_CONT) do_guess(5'($urandom), 1'b1, 1'b0, END_WIN, 1'b1, "rand_force");
            finish_game(1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
